// File: rtl/baggage_pkg.sv
// Shared definitions for the sequential baggage-drop controller:
// FSM state codes, seven-segment glyphs/words and derived-width helpers.
package baggage_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AVG  = 2'd1;
  localparam logic [1:0] ST_SQRT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_R = 7'b1010000;
  localparam logic [6:0] SEG_O = 7'b0111111;
  localparam logic [6:0] SEG_P = 7'b1110011;
  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_L = 7'b0111000;

  localparam logic [27:0] WORD_DROP = {SEG_D, SEG_R, SEG_O, SEG_P};
  localparam logic [27:0] WORD_COLD = {SEG_C, SEG_O, SEG_L, SEG_D};

  function automatic int sum_w(input int sensor_w, input int num_pairs);
    return sensor_w + $clog2(2 * num_pairs);
  endfunction

  function automatic int root_w(input int sensor_w, input int frac_w);
    return sensor_w / 2 + frac_w;
  endfunction

endpackage

// File: rtl/baggage_drop_seq_if.sv
// Request/result bundle between the sensor front end, the controller
// and the drop actuator/display.
interface baggage_drop_seq_if
  import baggage_pkg::*;
#(
  parameter int SENSOR_W  = 8,
  parameter int NUM_PAIRS = 2,
  parameter int FRAC_W    = 8,
  parameter int T_W       = 16
);
  localparam int ROOT_W = root_w(SENSOR_W, FRAC_W);

  logic                              start;
  logic [2*NUM_PAIRS*SENSOR_W-1:0]   sensors;
  logic [T_W-1:0]                    t_lim;
  logic                              drop_en;
  logic                              busy;
  logic                              done;
  logic                              error;
  logic [ROOT_W-1:0]                 t_act;
  logic                              drop_activated;
  logic [6:0]                        seven_seg1;
  logic [6:0]                        seven_seg2;
  logic [6:0]                        seven_seg3;
  logic [6:0]                        seven_seg4;

  modport master (
    output start, sensors, t_lim, drop_en,
    input  busy, done, error, t_act, drop_activated,
    input  seven_seg1, seven_seg2, seven_seg3, seven_seg4
  );

  modport slave (
    input  start, sensors, t_lim, drop_en,
    output busy, done, error, t_act, drop_activated,
    output seven_seg1, seven_seg2, seven_seg3, seven_seg4
  );

endinterface

// File: rtl/seq_sqrt.sv
// Bit-serial non-restoring integer square root, one root bit per cycle.
// The first bit is resolved on the start edge; done marks the cycle whose edge resolves the last bit.
module seq_sqrt #(
  parameter int WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] radicand,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   root
);
  localparam int RW    = WIDTH + 4;
  localparam int CNT_W = $clog2(WIDTH);

  logic [RW-1:0]      rem_q, rem_src, rem_sh, rem_nxt;
  logic [WIDTH-1:0]   root_src, root_nxt;
  logic [2*WIDTH-1:0] rad_q, rad_src;
  logic [CNT_W-1:0]   cnt_q;
  logic               running, go;

  assign go   = start && !running;
  assign busy = running;
  assign done = running && (cnt_q == CNT_W'(1));

  // Remainder kept in two's complement; its MSB selects subtract or add.
  always_comb begin
    rem_src  = go ? '0 : rem_q;
    root_src = go ? '0 : root;
    rad_src  = go ? radicand : rad_q;
    rem_sh   = RW'({rem_src, rad_src[2*WIDTH-1 -: 2]});
    if (!rem_src[RW-1])
      rem_nxt = rem_sh - {2'b00, root_src, 2'b01};
    else
      rem_nxt = rem_sh + {2'b00, root_src, 2'b11};
    root_nxt = {root_src[WIDTH-2:0], ~rem_nxt[RW-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q   <= '0;
      root    <= '0;
      rad_q   <= '0;
      cnt_q   <= '0;
      running <= 1'b0;
    end else begin
      if (go || running) begin
        rem_q <= rem_nxt;
        root  <= root_nxt;
        rad_q <= rad_src << 2;
      end
      if (go) begin
        cnt_q   <= CNT_W'(WIDTH - 1);
        running <= 1'b1;
      end else if (running) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1))
          running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/baggage_drop_seq.sv
// Sequential baggage-drop controller: pair-filtered rounded average,
// bit-serial square root, fall-time limit check and drop/cold display.
//
// state   | meaning
// IDLE    | waiting for start (ignored on the done cycle)
// AVG     | restoring division, one quotient bit per cycle
// SQRT    | seq_sqrt running on height << 2*FRAC_W
// DONE    | results (or the no-valid-pair error) registered on exit
module baggage_drop_seq
  import baggage_pkg::*;
#(
  parameter int SENSOR_W  = 8,
  parameter int NUM_PAIRS = 2,
  parameter int FRAC_W    = 8,
  parameter int T_W       = 16
) (
  input  logic clk,
  input  logic rst,
  baggage_drop_seq_if.slave bus
);
  localparam int SUM_W  = sum_w(SENSOR_W, NUM_PAIRS);
  localparam int ROOT_W = root_w(SENSOR_W, FRAC_W);
  localparam int P_W    = $clog2(NUM_PAIRS + 1);
  localparam int CNT_W  = $clog2(SUM_W);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt_q;
  logic [SUM_W-1:0]  quo_q, rem_q, div_q, sum_c, rem_nxt;
  logic [SUM_W:0]    rem_sh;
  logic [P_W-1:0]    pairs_c;
  logic              ge;
  logic              err_q, dren_q;
  logic [T_W-1:0]    tlim_q;
  logic              sqrt_start, sqrt_busy, sqrt_done;
  logic [ROOT_W-1:0] root, t_new, t_act_q;
  logic              le, drop_new, drop_q, done_q, error_q;
  logic [27:0]       seg_q;

  always_comb begin
    sum_c   = '0;
    pairs_c = '0;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      if (bus.sensors[2*k*SENSOR_W +: SENSOR_W] != '0 &&
          bus.sensors[(2*k+1)*SENSOR_W +: SENSOR_W] != '0) begin
        sum_c   = sum_c + SUM_W'(bus.sensors[2*k*SENSOR_W +: SENSOR_W])
                        + SUM_W'(bus.sensors[(2*k+1)*SENSOR_W +: SENSOR_W]);
        pairs_c = pairs_c + P_W'(1);
      end
    end
  end

  // Dividend shifts out of quo_q's MSB while quotient bits shift into its LSB.
  assign rem_sh  = {rem_q, quo_q[SUM_W-1]};
  assign ge      = rem_sh >= {1'b0, div_q};
  assign rem_nxt = ge ? SUM_W'(rem_sh - {1'b0, div_q}) : SUM_W'(rem_sh);

  assign sqrt_start = (state == ST_SQRT) && !sqrt_busy;

  seq_sqrt #(.WIDTH(ROOT_W)) u_sqrt (
    .clk      (clk),
    .rst      (rst),
    .start    (sqrt_start),
    .radicand ({quo_q[SENSOR_W-1:0], {2*FRAC_W{1'b0}}}),
    .busy     (sqrt_busy),
    .done     (sqrt_done),
    .root     (root)
  );

  assign t_new    = root >> 1;
  assign le       = {{T_W{1'b0}}, t_new} <= {{ROOT_W{1'b0}}, tlim_q};
  assign drop_new = dren_q && le;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      err_q   <= 1'b0;
      dren_q  <= 1'b0;
      tlim_q  <= '0;
      t_act_q <= '0;
      drop_q  <= 1'b0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
      seg_q   <= WORD_COLD;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && !done_q) begin
            quo_q  <= sum_c + SUM_W'(pairs_c);
            rem_q  <= '0;
            div_q  <= SUM_W'({pairs_c, 1'b0});
            err_q  <= (pairs_c == '0);
            dren_q <= bus.drop_en;
            tlim_q <= bus.t_lim;
            cnt_q  <= CNT_W'(SUM_W - 1);
            state  <= (pairs_c == '0) ? ST_DONE : ST_AVG;
          end
        end
        ST_AVG: begin
          quo_q <= {quo_q[SUM_W-2:0], ge};
          rem_q <= rem_nxt;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0)
            state <= ST_SQRT;
        end
        ST_SQRT: begin
          if (sqrt_done)
            state <= ST_DONE;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b1;
          if (err_q) begin
            error_q <= 1'b1;
            t_act_q <= '0;
            drop_q  <= 1'b0;
            seg_q   <= WORD_COLD;
          end else begin
            error_q <= 1'b0;
            t_act_q <= t_new;
            drop_q  <= drop_new;
            seg_q   <= drop_new ? WORD_DROP : WORD_COLD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy           = (state != ST_IDLE);
  assign bus.done           = done_q;
  assign bus.error          = error_q;
  assign bus.t_act          = t_act_q;
  assign bus.drop_activated = drop_q;
  assign bus.seven_seg1     = seg_q[27:21];
  assign bus.seven_seg2     = seg_q[20:14];
  assign bus.seven_seg3     = seg_q[13:7];
  assign bus.seven_seg4     = seg_q[6:0];

endmodule

// File: tb/tb_baggage_drop_seq.sv
// Directed bench for baggage_drop_seq: default instance plus a three-pair instance.
module tb_baggage_drop_seq;

  localparam logic [31:0] EXP_DROP = {4'h0, 7'b1011110, 7'b1010000, 7'b0111111, 7'b1110011};
  localparam logic [31:0] EXP_COLD = {4'h0, 7'b0111001, 7'b0111111, 7'b0111000, 7'b1011110};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   lat;
  int   n;

  always #5 clk = ~clk;

  baggage_drop_seq_if #(.SENSOR_W(8), .NUM_PAIRS(2), .FRAC_W(8), .T_W(16)) if0 ();
  baggage_drop_seq_if #(.SENSOR_W(8), .NUM_PAIRS(3), .FRAC_W(8), .T_W(16)) if1 ();

  baggage_drop_seq #(.SENSOR_W(8), .NUM_PAIRS(2), .FRAC_W(8), .T_W(16)) u0 (
    .clk(clk), .rst(rst), .bus(if0));
  baggage_drop_seq #(.SENSOR_W(8), .NUM_PAIRS(3), .FRAC_W(8), .T_W(16)) u1 (
    .clk(clk), .rst(rst), .bus(if1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] disp0();
    return {4'h0, if0.seven_seg1, if0.seven_seg2, if0.seven_seg3, if0.seven_seg4};
  endfunction

  task automatic launch0(input logic [31:0] sens, input logic [15:0] tl, input logic de);
    @(negedge clk);
    if0.sensors = sens;
    if0.t_lim   = tl;
    if0.drop_en = de;
    if0.start   = 1'b1;
    @(negedge clk);
    if0.start   = 1'b0;
  endtask

  // Counts edges after the acceptance edge until done; optionally pulses start at cycle poke.
  task automatic wait0(input int poke, output int cycles);
    cycles = 0;
    while (!if0.done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if0.start = (cycles == poke);
    end
    if0.start = 1'b0;
  endtask

  initial begin
    if0.start = 0; if0.sensors = '0; if0.t_lim = '0; if0.drop_en = 0;
    if1.start = 0; if1.sensors = '0; if1.t_lim = '0; if1.drop_en = 0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_busy",  if0.busy, 0);
    check("rst_done",  if0.done, 0);
    check("rst_error", if0.error, 0);
    check("rst_t_act", if0.t_act, 0);
    check("rst_drop",  if0.drop_activated, 0);
    check("rst_disp",  disp0(), EXP_COLD);

    // sensors 9,0,16,16: pair 0 dropped, height 16, t_act 0x200 == t_lim
    launch0({8'd16, 8'd16, 8'd0, 8'd9}, 16'h0200, 1'b1);
    check("t1_busy_after_accept", if0.busy, 1);
    check("t1_done_after_accept", if0.done, 0);
    wait0(-1, lat);
    check("t1_latency", lat, 23);
    check("t1_t_act",   if0.t_act, 32'h200);
    check("t1_drop",    if0.drop_activated, 1);
    check("t1_error",   if0.error, 0);
    check("t1_disp",    disp0(), EXP_DROP);
    check("t1_busy_on_done", if0.busy, 0);
    @(negedge clk);
    check("t1_done_one_cycle", if0.done, 0);
    check("t1_t_act_held", if0.t_act, 32'h200);

    // sensors 100,100,100,101: height 100, t_act 0x500 > 0x4FF
    launch0({8'd101, 8'd100, 8'd100, 8'd100}, 16'h04FF, 1'b1);
    wait0(-1, lat);
    check("t2_latency", lat, 23);
    check("t2_t_act",   if0.t_act, 32'h500);
    check("t2_drop",    if0.drop_activated, 0);
    check("t2_disp",    disp0(), EXP_COLD);

    // sensors 1,2,2,2: height 2, root 0x16A, t_act 0xB5; drop_en low
    launch0({8'd2, 8'd2, 8'd2, 8'd1}, 16'h00B5, 1'b0);
    wait0(-1, lat);
    check("t3_t_act", if0.t_act, 32'h0B5);
    check("t3_drop",  if0.drop_activated, 0);
    check("t3_disp",  disp0(), EXP_COLD);

    // same with drop_en high: equality t_act == t_lim permits the drop
    launch0({8'd2, 8'd2, 8'd2, 8'd1}, 16'h00B5, 1'b1);
    wait0(-1, lat);
    check("t3b_drop", if0.drop_activated, 1);
    check("t3b_disp", disp0(), EXP_DROP);

    // one below: 0xB5 > 0xB4
    launch0({8'd2, 8'd2, 8'd2, 8'd1}, 16'h00B4, 1'b1);
    wait0(-1, lat);
    check("t3c_drop", if0.drop_activated, 0);

    // sensors 0,5,0,7: no valid pair
    launch0({8'd7, 8'd0, 8'd5, 8'd0}, 16'hFFFF, 1'b1);
    wait0(-1, lat);
    check("err_latency", lat, 1);
    check("err_error",   if0.error, 1);
    check("err_t_act",   if0.t_act, 0);
    check("err_drop",    if0.drop_activated, 0);
    check("err_disp",    disp0(), EXP_COLD);

    launch0({8'd16, 8'd16, 8'd0, 8'd9}, 16'h0200, 1'b1);
    wait0(-1, lat);
    check("err_cleared", if0.error, 0);
    check("err_clr_t_act", if0.t_act, 32'h200);

    // start pulsed during SQRT is ignored
    launch0({8'd101, 8'd100, 8'd100, 8'd100}, 16'h04FF, 1'b1);
    wait0(15, lat);
    check("ign_latency", lat, 23);
    check("ign_t_act",   if0.t_act, 32'h500);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (if0.done) n++;
    end
    check("ign_no_second_done", n, 0);
    check("ign_idle_busy", if0.busy, 0);

    // reset mid-SQRT after a DROP result
    launch0({8'd16, 8'd16, 8'd0, 8'd9}, 16'h0200, 1'b1);
    wait0(-1, lat);
    launch0({8'd2, 8'd2, 8'd2, 8'd1}, 16'h00B5, 1'b1);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_busy",  if0.busy, 0);
    check("mrst_t_act", if0.t_act, 0);
    check("mrst_drop",  if0.drop_activated, 0);
    check("mrst_disp",  disp0(), EXP_COLD);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (if0.done) n++;
    end
    check("mrst_no_done", n, 0);
    launch0({8'd2, 8'd2, 8'd2, 8'd1}, 16'h00B5, 1'b1);
    wait0(-1, lat);
    check("mrst_fresh_latency", lat, 23);
    check("mrst_fresh_t_act",   if0.t_act, 32'h0B5);

    // three-pair instance: 4,4,0,9,16,16 -> height 10, root 0x329, t_act 0x194
    @(negedge clk);
    if1.sensors = {8'd16, 8'd16, 8'd9, 8'd0, 8'd4, 8'd4};
    if1.t_lim   = 16'h0194;
    if1.drop_en = 1'b1;
    if1.start   = 1'b1;
    @(negedge clk);
    if1.start   = 1'b0;
    lat = 0;
    while (!if1.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("np3_latency", lat, 24);
    check("np3_t_act",   if1.t_act, 32'h194);
    check("np3_drop",    if1.drop_activated, 1);
    check("np3_error",   if1.error, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/baggage_drop_seq.md
# baggage_drop_seq

Clocked, parametrised successor to the combinational baggage-drop datapath. It averages a configurable number of sensor pairs, discarding any pair with a zero reading. It then takes a fixed-point square root with an iterative bit-serial engine and derives the fall time as half the root. Finally it compares that time with a limit and drives the drop-enable output and the four-digit "drop"/"cold" display. It sits between the sensor front end and the drop actuator, under a start/busy/done handshake.

## Interface
- SENSOR_W, 8: sensor reading width; must be even.
- NUM_PAIRS, 2: number of sensor pairs; sensor 2k and sensor 2k+1 form pair k.
- FRAC_W, 8: fractional bits of the root and of the fall time.
- T_W, 16: width of t_lim.
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  one-cycle request; accepted only in IDLE.
- sensors  in  2*NUM_PAIRS*SENSOR_W  packed readings; sensor i is at bits [i*SENSOR_W +: SENSOR_W].
- t_lim  in  T_W  time limit, unsigned, FRAC_W fractional bits.
- drop_en  in  1  drop permission.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse when the results update.
- error  out  1  set when no pair was valid in the last measurement.
- t_act  out  ROOT_W  last fall time.
- drop_activated  out  1  last drop decision.
- seven_seg1..seven_seg4  out  7 each  display digits, leftmost digit first.

## Operation
- Derived widths: SUM_W = SENSOR_W + clog2(2*NUM_PAIRS); ROOT_W = SENSOR_W/2 + FRAC_W.
- Reset values:
  - busy, done, error, drop_activated, t_act are all 0.
  - Display shows COLD.
  - FSM is in IDLE.
- Start accepted in IDLE:
  - sensors, t_lim and drop_en are registered.
  - Pair k is valid iff both of its readings are nonzero.
  - sum = sum of the readings in valid pairs; P = number of valid pairs.
- P = 0: go to DONE. Set error=1, t_act=0, drop_activated=0, display COLD.
- P > 0: the FSM steps through the following states.
  - AVG: restoring division, one quotient bit per cycle, SUM_W cycles. It computes height = floor((sum + P) / (2P)), which is round-half-up of the mean.
  - SQRT: non-restoring integer square root of height << 2*FRAC_W, one root bit per cycle, ROOT_W cycles. The result root is truncated.
  - DONE (one cycle): t_act = root >> 1 (truncating); error=0.
    - drop_activated = drop_en AND (t_act <= t_lim). The comparison is unsigned and zero-extends the narrower operand.
    - Display shows DROP when drop_activated=1, otherwise COLD.
  - DONE then returns to IDLE.
- start while busy is ignored; it is neither queued nor restarts the measurement.
- Outputs hold their last values until the next DONE.
- Reset asserted mid-operation returns immediately to the reset values. A measurement interrupted by reset produces no done.

## Timing
- Start accepted at edge k.
- Normal path:
  - busy rises after edge k.
  - done and the updated outputs appear after edge k+SUM_W+ROOT_W+1 and last one cycle.
  - busy falls with that same edge.
- Default latency is 23 cycles (SUM_W=10, ROOT_W=12).
- Error path: done after edge k+1.
- New start: accepted in the cycle immediately after done. There is no back-to-back start on the done cycle itself.
- Inputs other than start are don't-care except at the acceptance edge.

## Structure
- Shared package baggage_pkg holds:
  - the FSM state enum;
  - the seven-segment glyph constants (D, R, O, P, C, L);
  - the DROP and COLD four-digit words;
  - the width helper functions for SUM_W and ROOT_W.
- Sub-module seq_sqrt(WIDTH), with start/done handshake, holds the SQRT engine and is reusable elsewhere.
- The divider, FSM and output registers stay in the top module.

## Test plan
- Sensors 9,0,16,16; t_lim=0x0200; drop_en=1 -> pair 0 discarded, height 16, t_act=0x200, drop_activated=1, DROP, done at 23 cycles.
- Sensors 100,100,100,101; t_lim=0x04FF -> height 100, t_act=0x500, drop_activated=0, COLD.
- Sensors 1,2,2,2 -> height 2, root 0x16A, t_act=0x0B5; t_lim=0x00B5 with drop_en=0 -> drop_activated=0, COLD.
- Sensors 0,5,0,7 -> error=1, t_act=0, COLD, done one cycle after acceptance; a following valid measurement clears error.
- start pulsed again during SQRT -> ignored, single done. Reset asserted mid-SQRT -> outputs return to reset values at once, no done. A fresh start afterwards then completes normally.
- NUM_PAIRS=3 instance, sensors 4,4,0,9,16,16 -> height round(40/4)=10, root 0x329, t_act=0x194.
